// File: rtl/merge_2to1_node_if.sv
`default_nettype none
// ============================================================================
//  Module   : merge_2to1_node_if
//  Purpose  : Bundles the two sorted input streams (A, B), the merged output
//             stream and the order-error flag of merge_2to1_node.
//  Modports : master - the environment side (drives inputs, takes outputs)
//             slave  - the merge node side
//  Signals  : a_valid/a_data/a_ready    sorted input run A
//             b_valid/b_data/b_ready    sorted input run B
//             out_valid/out_data/out_last/out_ready  merged output run
//             order_err                 sticky unsorted-input flag
//  Revision : 1.0 - initial release
// ============================================================================
interface merge_2to1_node_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  a_valid;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_ready;
  logic                  b_valid;
  logic [DATA_WIDTH-1:0] b_data;
  logic                  b_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;
  logic                  order_err;

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_last, order_err
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_last, order_err
  );
endinterface
`default_nettype wire

// File: rtl/merge_2to1_node.sv
`default_nettype none
// ============================================================================
//  Module   : merge_2to1_node
//  Purpose  : Merges two ascending runs of RUN_LEN elements into one ascending
//             run of 2*RUN_LEN elements. Ties take A first (stable merge).
//             Output is a single register stage with valid/ready backpressure.
//  Ports    : clk  - single clock, rising edge
//             rst  - synchronous, active-high reset
//             bus  - merge_2to1_node_if.slave (A, B, merged output, order_err)
//  Params   : DATA_WIDTH - element width (unsigned)
//             RUN_LEN    - elements per input run (>= 1)
//  Macro    : MERGE_ORDER_CHECK_EN - when defined, order_err flags an input
//             element smaller than its predecessor on the same side within a
//             run; otherwise order_err is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module merge_2to1_node #(
  parameter int DATA_WIDTH = 8,
  parameter int RUN_LEN    = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  merge_2to1_node_if.slave  bus
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam int TOT_W = CNT_W + 1;
  // Counter value at which the next accept fills one side.
  localparam logic [CNT_W-1:0] SIDE_LAST = CNT_W'(RUN_LEN - 1);
  // cnt_a + cnt_b value at which the next accept is the last of the run.
  localparam logic [TOT_W-1:0] RUN_LAST  = TOT_W'(2 * RUN_LEN - 1);

  localparam logic [1:0] MERGE   = 2'd0;
  localparam logic [1:0] DRAIN_A = 2'd1;
  localparam logic [1:0] DRAIN_B = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt_a;
  logic [CNT_W-1:0]      cnt_b;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_q;

  logic                  load_en;
  logic                  a_rdy;
  logic                  b_rdy;
  logic                  acc_a;
  logic                  acc_b;
  logic                  acc;
  logic                  last_elem;
  logic [TOT_W-1:0]      total;

  // The output register can take a new element when it is empty or being
  // drained this cycle; every ready is qualified by this.
  assign load_en = !vld_q || bus.out_ready;

  always_comb begin
    a_rdy = 1'b0;
    b_rdy = 1'b0;
    case (state)
      MERGE: begin
        // Compare only when both heads are present; A wins ties.
        if (bus.a_valid && bus.b_valid) begin
          a_rdy = load_en && (bus.a_data <= bus.b_data);
          b_rdy = load_en && (bus.a_data >  bus.b_data);
        end
      end
      DRAIN_A: a_rdy = load_en;
      DRAIN_B: b_rdy = load_en;
      default: begin
        a_rdy = 1'b0;
        b_rdy = 1'b0;
      end
    endcase
    if (rst) begin
      a_rdy = 1'b0;
      b_rdy = 1'b0;
    end
  end

  assign acc_a     = bus.a_valid && a_rdy;
  assign acc_b     = bus.b_valid && b_rdy;
  assign acc       = acc_a || acc_b;
  assign total     = {1'b0, cnt_a} + {1'b0, cnt_b};
  assign last_elem = (total == RUN_LAST);

  // Run control: counters and merge/drain state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MERGE;
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (acc) begin
      if (last_elem) begin
        state <= MERGE;
        cnt_a <= '0;
        cnt_b <= '0;
      end else begin
        if (acc_a) cnt_a <= cnt_a + 1'b1;
        if (acc_b) cnt_b <= cnt_b + 1'b1;
        case (state)
          MERGE: begin
            // One side exhausted: the rest of the run comes from the other.
            if (acc_a && (cnt_a == SIDE_LAST)) state <= DRAIN_B;
            if (acc_b && (cnt_b == SIDE_LAST)) state <= DRAIN_A;
          end
          DRAIN_A, DRAIN_B: state <= state;
          default:          state <= MERGE;
        endcase
      end
    end else if (state != MERGE && state != DRAIN_A && state != DRAIN_B) begin
      state <= MERGE;
    end
  end

  // Output register: holds while stalled, empties when drained with no input.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      last_q <= 1'b0;
    end else if (load_en) begin
      vld_q <= acc;
      if (acc) begin
        data_q <= acc_a ? bus.a_data : bus.b_data;
        last_q <= last_elem;
      end else begin
        last_q <= 1'b0;
      end
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.out_valid = vld_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;

`ifdef MERGE_ORDER_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_a;
  logic [DATA_WIDTH-1:0] prev_b;
  logic                  err_q;

  // A non-zero side counter means a predecessor from this run exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a <= '0;
      prev_b <= '0;
      err_q  <= 1'b0;
    end else begin
      if (acc_a) begin
        prev_a <= bus.a_data;
        if ((cnt_a != '0) && (bus.a_data < prev_a)) err_q <= 1'b1;
      end
      if (acc_b) begin
        prev_b <= bus.b_data;
        if ((cnt_b != '0) && (bus.b_data < prev_b)) err_q <= 1'b1;
      end
    end
  end

  assign bus.order_err = err_q;
`else
  assign bus.order_err = 1'b0;
`endif

endmodule
`default_nettype wire
